// File: rtl/three_to_one_pkg.sv
// Shared types and constants for the three_to_one redundant-frame merger.
// Optional lost-frame counter is enabled with THREE_TO_ONE_LOSTCNT_EN.
package three_to_one_pkg;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_OUTPUT = 1'b1
  } state_t;

  localparam logic [7:0] ID_MIN      = 8'd1;
  localparam logic [7:0] ID_MAX      = 8'd3;
  localparam logic [7:0] ID_OUT_BYTE = 8'h01;

  function automatic logic [7:0] maj3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/t2o_slot_ram.sv
// One copy buffer: MAX_LEN x 8 byte RAM with registered read plus the stored frame length.
module t2o_slot_ram
  import three_to_one_pkg::*;
#(
  parameter int MAX_LEN = 2048,
  parameter int AW      = $clog2(MAX_LEN),
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata,
  input  logic          i_len_we,
  input  logic [LW-1:0] i_len,
  output logic [LW-1:0] o_len
);

  logic [7:0]    r_mem [MAX_LEN];
  logic [7:0]    r_rdata;
  logic [LW-1:0] r_len;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst)           r_len <= '0;
    else if (i_len_we) r_len <= i_len;
  end

  assign o_rdata = r_rdata;
  assign o_len   = r_len;

endmodule

// File: rtl/three_to_one.sv
// Merges three redundant copies of a frame by per-byte bitwise vote; flags lost copies.
// Define THREE_TO_ONE_LOSTCNT_EN to add the saturating lost_count output.
module three_to_one
  import three_to_one_pkg::*;
#(
  parameter int WHEREIS_ID   = 0,
  parameter int MAX_LEN      = 2048,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en_w,
  input  logic [7:0]  rxdata_w,
  output logic        en_out,
  output logic [7:0]  data_out,
  output logic        lost
`ifdef THREE_TO_ONE_LOSTCNT_EN
  ,output logic [15:0] lost_count
`endif
);

  localparam int AW  = $clog2(MAX_LEN);
  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int DLY = WHEREIS_ID + 1;
  localparam int RCW = $clog2(WHEREIS_ID + 2) + 1;
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

  // Delay line so the id byte is captured before byte 0 reaches the slot RAM
  logic [DLY-1:0] r_dly_en;
  logic [7:0]     r_dly_data [DLY];
  logic [RCW-1:0] r_raw_cnt;
  logic [7:0]     r_id;
  logic           r_id_strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_en    <= '0;
      r_raw_cnt   <= '0;
      r_id        <= '0;
      r_id_strobe <= 1'b0;
    end else begin
      r_dly_en[0] <= rx_en_w;
      for (int k = 1; k < DLY; k++) r_dly_en[k] <= r_dly_en[k-1];
      r_id_strobe <= rx_en_w && (r_raw_cnt == RCW'(WHEREIS_ID));
      if (rx_en_w && (r_raw_cnt == RCW'(WHEREIS_ID))) r_id <= rxdata_w;
      if (!rx_en_w)                                  r_raw_cnt <= '0;
      else if (r_raw_cnt != RCW'(WHEREIS_ID + 1))    r_raw_cnt <= r_raw_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_dly_data[0] <= rxdata_w;
    for (int k = 1; k < DLY; k++) r_dly_data[k] <= r_dly_data[k-1];
  end

  logic       w_d_en;
  logic [7:0] w_d_data;
  logic       r_d_en_q;
  assign w_d_en   = r_dly_en[DLY-1];
  assign w_d_data = r_dly_data[DLY-1];

  always_ff @(posedge clk) begin
    if (rst) r_d_en_q <= 1'b0;
    else     r_d_en_q <= w_d_en;
  end

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_full;
  logic           r_wr_active;
  slot_idx_t      r_wr_slot;
  logic [LW-1:0]  r_wr_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic [AW-1:0]  r_rd_addr;
  logic           r_en_out, r_out_last, r_lost;
  logic [AW-1:0]  r_out_idx;
  logic [7:0]     w_q   [3];
  logic [LW-1:0]  w_len [3];

  logic           w_start, w_id_ok, w_slot_busy, w_accept, w_close, w_timeout, w_to_run;
  logic           w_frame_end, w_wr_go, w_we, w_last_rd;
  slot_idx_t      w_id_slot, w_wr_slot;
  logic [LW-1:0]  w_wr_cnt, w_low_len;

  assign w_start     = w_d_en && !r_d_en_q;
  assign w_id_ok     = (r_id >= ID_MIN) && (r_id <= ID_MAX);
  assign w_id_slot   = slot_idx_t'(r_id[1:0] - 2'd1);
  assign w_slot_busy = |(r_full & (3'b001 << w_id_slot));
  assign w_accept    = w_start && r_id_strobe && w_id_ok && !w_slot_busy &&
                       (r_state == S_IDLE) && !r_en_out && !w_close;
  assign w_wr_go     = w_d_en && (w_accept || r_wr_active);
  assign w_wr_slot   = w_accept ? w_id_slot : r_wr_slot;
  assign w_wr_cnt    = w_accept ? '0 : r_wr_cnt;
  assign w_we        = w_wr_go && (w_wr_cnt < LW'(MAX_LEN));
  assign w_frame_end = r_wr_active && !w_d_en;

  // Timeout only runs while the input is fully quiet and a partial group waits
  assign w_to_run  = (r_state == S_IDLE) && !r_en_out && (|r_full) &&
                     !rx_en_w && !w_d_en && !r_wr_active;
  assign w_timeout = w_to_run && (r_to_cnt == TW'(IDLE_TIMEOUT - 1));
  assign w_close   = (r_state == S_IDLE) && !r_en_out &&
                     ((w_frame_end && (r_wr_slot == 2'd2)) || w_timeout);

  assign w_low_len = r_full[0] ? w_len[0] : (r_full[1] ? w_len[1] : w_len[2]);
  assign w_last_rd = ({1'b0, r_rd_addr} == (w_low_len - LW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_active <= 1'b0;
      r_wr_slot   <= '0;
      r_wr_cnt    <= '0;
      r_full      <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_wr_active <= 1'b1;
        r_wr_slot   <= w_id_slot;
        r_wr_cnt    <= LW'(1);
      end else if (r_wr_active) begin
        if (w_d_en) begin
          if (r_wr_cnt < LW'(MAX_LEN)) r_wr_cnt <= r_wr_cnt + 1'b1;
        end else begin
          r_wr_active <= 1'b0;
          r_full      <= r_full | (3'b001 << r_wr_slot);
        end
      end
      if (r_en_out && r_out_last) r_full <= '0;
      r_to_cnt <= (w_to_run && !w_timeout) ? r_to_cnt + 1'b1 : '0;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_slot
    t2o_slot_ram #(.MAX_LEN(MAX_LEN), .AW(AW), .LW(LW)) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we && (w_wr_slot == 2'(g))),
      .i_waddr  (w_wr_cnt[AW-1:0]),
      .i_wdata  (w_d_data),
      .i_raddr  (r_rd_addr),
      .o_rdata  (w_q[g]),
      .i_len_we (w_frame_end && (r_wr_slot == 2'(g))),
      .i_len    (r_wr_cnt),
      .o_len    (w_len[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_close)   w_state_nxt = S_OUTPUT;
      S_OUTPUT: if (w_last_rd) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Output pipeline: read issued in OUTPUT, byte appears one cycle later with en_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr  <= '0;
      r_en_out   <= 1'b0;
      r_out_last <= 1'b0;
      r_out_idx  <= '0;
      r_lost     <= 1'b0;
    end else begin
      r_rd_addr  <= (r_state == S_OUTPUT) ? r_rd_addr + 1'b1 : '0;
      r_en_out   <= (r_state == S_OUTPUT);
      r_out_last <= (r_state == S_OUTPUT) && w_last_rd;
      r_out_idx  <= r_rd_addr;
      if ((r_state == S_OUTPUT) && !r_en_out) r_lost <= ~&r_full;
      else if (r_en_out && r_out_last)        r_lost <= 1'b0;
    end
  end

  logic [7:0] w_byte [3];
  logic [7:0] w_voted;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_byte[i] = (r_full[i] && ({1'b0, r_out_idx} < w_len[i])) ? w_q[i] : 8'h00;
    end
    if (&r_full)        w_voted = maj3(w_byte[0], w_byte[1], w_byte[2]);
    else if (r_full[0]) w_voted = w_byte[0];
    else if (r_full[1]) w_voted = w_byte[1];
    else                w_voted = w_byte[2];
  end

  assign en_out   = r_en_out;
  assign lost     = r_lost;
  assign data_out = !r_en_out ? 8'h00 :
                    (r_out_idx == AW'(WHEREIS_ID)) ? ID_OUT_BYTE : w_voted;

`ifdef THREE_TO_ONE_LOSTCNT_EN
  logic [15:0] r_lost_count;
  always_ff @(posedge clk) begin
    if (rst) r_lost_count <= '0;
    else if (r_en_out && r_out_last && r_lost && (r_lost_count != 16'hFFFF))
      r_lost_count <= r_lost_count + 1'b1;
  end
  assign lost_count = r_lost_count;
`endif

endmodule

// File: tb/tb_three_to_one.sv
// Scoreboard bench for three_to_one: expected {lost,byte} pairs queued at stimulus time.
module tb_three_to_one;

  logic       clk;
  logic       rst;
  logic       rx_en_w;
  logic [7:0] rxdata_w;
  logic       en_out;
  logic [7:0] data_out;
  logic       lost;
`ifdef THREE_TO_ONE_LOSTCNT_EN
  logic [15:0] lost_count;
`endif

  three_to_one dut (
    .clk      (clk),
    .rst      (rst),
    .rx_en_w  (rx_en_w),
    .rxdata_w (rxdata_w),
    .en_out   (en_out),
    .data_out (data_out),
    .lost     (lost)
`ifdef THREE_TO_ONE_LOSTCNT_EN
    ,.lost_count (lost_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         n_frames = 0;
  logic       prev_en  = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] pay [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic new_payload();
    pay[0] = 8'h00;
    for (int i = 1; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp(input logic lost_e);
    for (int i = 0; i < 8; i++) exp_q.push_back({lost_e, (i == 0) ? 8'h01 : pay[i]});
  endtask

  task automatic send_frame(input logic [7:0] id, input int flip_idx,
                            input logic [7:0] mask, input int gap);
    for (int i = 0; i < 8; i++) begin
      rx_en_w  = 1'b1;
      rxdata_w = (i == 0) ? id : (pay[i] ^ ((i == flip_idx) ? mask : 8'h00));
      @(posedge clk); #1;
    end
    rx_en_w  = 1'b0;
    rxdata_w = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(posedge clk); #1; t++; end
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (en_out) begin
        if (!prev_en) n_frames++;
        if (exp_q.size() == 0) check("unexpected_out", en_out, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("out_byte", {lost, data_out}, e);
        end
      end else begin
        check("idle_data", data_out, 8'h00);
      end
    end
    prev_en = en_out;
  end

  initial begin
    int t;
    rst      = 1'b1;
    rx_en_w  = 1'b0;
    rxdata_w = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_en_out", en_out, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_lost", lost, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // clean triple
    new_payload(); push_exp(1'b0);
    send_frame(8'd1, -1, 8'h00, 1);
    send_frame(8'd2, -1, 8'h00, 1);
    send_frame(8'd3, -1, 8'h00, 1);
    wait_drain(100);

    // single bit flip in copy 2 is voted out
    new_payload(); push_exp(1'b0);
    send_frame(8'd1, -1, 8'h00, 1);
    send_frame(8'd2, 3, 8'h10, 1);
    send_frame(8'd3, -1, 8'h00, 1);
    wait_drain(100);

    // missing copy 3: copy 1 wins over a corrupted copy 2, lost flagged after timeout
    new_payload(); push_exp(1'b1);
    send_frame(8'd1, -1, 8'h00, 1);
    send_frame(8'd2, 5, 8'h0F, 1);
    wait_drain(300);
`ifdef THREE_TO_ONE_LOSTCNT_EN
    check("lost_count", lost_count, 16'd1);
`endif

    // bad id frame is dropped
    new_payload(); push_exp(1'b0);
    send_frame(8'd1, -1, 8'h00, 1);
    send_frame(8'd7, 2, 8'hFF, 1);
    send_frame(8'd2, -1, 8'h00, 1);
    send_frame(8'd3, -1, 8'h00, 1);
    wait_drain(100);

    // back-to-back groups
    for (int g = 0; g < 30; g++) begin
      new_payload(); push_exp(1'b0);
      send_frame(8'd1, -1, 8'h00, 1);
      send_frame(8'd2, -1, 8'h00, 1);
      send_frame(8'd3, -1, 8'h00, 10);
    end
    wait_drain(300);

    // reset while the output frame is at byte 4
    new_payload(); push_exp(1'b0);
    send_frame(8'd1, -1, 8'h00, 1);
    send_frame(8'd2, -1, 8'h00, 1);
    send_frame(8'd3, -1, 8'h00, 1);
    t = 0;
    while (exp_q.size() > 4 && t < 200) begin @(posedge clk); #1; t++; end
    check("reach_byte4", exp_q.size(), 4);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("abort_en_out", en_out, 1'b0);
    check("abort_data", data_out, 8'h00);
    check("abort_lost", lost, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) begin @(posedge clk); #1; end

    // clean triple after the abort
    new_payload(); push_exp(1'b0);
    send_frame(8'd1, -1, 8'h00, 1);
    send_frame(8'd2, -1, 8'h00, 1);
    send_frame(8'd3, -1, 8'h00, 1);
    wait_drain(100);

    repeat (20) begin @(posedge clk); #1; end
    check("frame_count", n_frames, 36);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
